// File: rtl/scs8hd_pwrseq_tap.sv
// -----------------------------------------------------------------------------
// scs8hd_pwrseq_tap
//
// Power-switch sequencer for a gated domain. Header-switch segments are turned
// on one at a time, STEP_CYC cycles apart, to limit rush current, and turned
// off in reverse order. Completion is reported on a level req/ack handshake.
//
// Parameters
//   NSEG      number of switch segments (1..32)
//   STEP_CYC  cycles between consecutive segment changes (1..255)
//
// Ports
//   clk       sequencer clock, rising edge
//   reset     synchronous, active-high
//   pwr_req   level request: 1 = domain on, 0 = domain off
//   pwr_ack   1 only when all segments are on and the ramp has settled
//   sw_en     per-segment switch enables, thermometer code from bit 0
//   seq_busy  1 while ramping up or down
//   iso_en    isolation-clamp enable (only with SC_PWRSEQ_ISO_EN defined)
//
// Optional feature: define SC_PWRSEQ_ISO_EN to add iso_en and its sequencing.
// Isolation is released one cycle before pwr_ack rises, and re-asserted one
// cycle before the first segment drops.
// -----------------------------------------------------------------------------
module scs8hd_pwrseq_tap #(
    parameter int NSEG     = 4,
    parameter int STEP_CYC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pwr_req,
    output logic            pwr_ack,
    output logic [NSEG-1:0] sw_en,
    output logic            seq_busy
`ifdef SC_PWRSEQ_ISO_EN
    ,
    output logic            iso_en
`endif
);

    localparam int CW = $clog2(STEP_CYC + 1);

    localparam logic [CW-1:0]   RELOAD  = CW'(STEP_CYC - 1);
    localparam logic [NSEG-1:0] SEG_ONE = NSEG'(1);
    localparam logic [NSEG-1:0] SEG_ALL = '1;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RAMP_UP = 2'd1,
        ON      = 2'd2,
        RAMP_DN = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NSEG-1:0] sw_nxt;
    logic            ack_nxt;
    logic            busy_nxt;

    // NOTE: every variable driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sw_nxt    = sw_en;

        unique case (state)
            OFF: begin
                if (pwr_req) begin
                    state_nxt = RAMP_UP;
                    sw_nxt    = SEG_ONE;
                    cnt_nxt   = RELOAD;
                end
            end

            RAMP_UP: begin
                if (!pwr_req) begin
                    // Reversal: hold the segments, restart the interval.
                    state_nxt = RAMP_DN;
                    cnt_nxt   = RELOAD;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (sw_en == SEG_ALL) begin
                    // Settle interval after the last segment has elapsed.
                    state_nxt = ON;
                end else begin
                    sw_nxt  = (sw_en << 1) | SEG_ONE;
                    cnt_nxt = RELOAD;
                end
            end

            ON: begin
                if (!pwr_req) begin
                    state_nxt = RAMP_DN;
`ifdef SC_PWRSEQ_ISO_EN
                    // Clamp first; the top segment drops on the next edge.
                    cnt_nxt   = '0;
`else
                    sw_nxt    = sw_en >> 1;
                    cnt_nxt   = RELOAD;
                    if ((sw_en >> 1) == '0) begin
                        state_nxt = OFF;
                    end
`endif
                end
            end

            RAMP_DN: begin
                if (pwr_req) begin
                    state_nxt = RAMP_UP;
                    cnt_nxt   = RELOAD;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    sw_nxt  = sw_en >> 1;
                    cnt_nxt = RELOAD;
                    if ((sw_en >> 1) == '0) begin
                        state_nxt = OFF;
                    end
                end
            end

            default: begin
                state_nxt = OFF;
                sw_nxt    = '0;
                cnt_nxt   = '0;
            end
        endcase

`ifdef SC_PWRSEQ_ISO_EN
        // Acknowledge one cycle after isolation has been released.
        ack_nxt  = (state == ON) && (state_nxt == ON);
`else
        ack_nxt  = (state_nxt == ON);
`endif
        busy_nxt = (state_nxt == RAMP_UP) || (state_nxt == RAMP_DN);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= OFF;
            cnt      <= '0;
            sw_en    <= '0;
            pwr_ack  <= 1'b0;
            seq_busy <= 1'b0;
`ifdef SC_PWRSEQ_ISO_EN
            iso_en   <= 1'b1;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sw_en    <= sw_nxt;
            pwr_ack  <= ack_nxt;
            seq_busy <= busy_nxt;
`ifdef SC_PWRSEQ_ISO_EN
            iso_en   <= (state_nxt != ON);
`endif
        end
    end

endmodule
